mux_arb_n: RTL
==============

Name: mux_arb_n

Overview:
- N-channel, parametrised-width registered multiplexer: the successor to the 2:1 combinational MUX.
- Selects one of NUM_CH valid/ready input channels and registers the selected word plus its channel index on a single output channel.
- Selection is a runtime mode: explicit select, fixed priority, or round-robin.
- Sits between multiple producers (register-file read ports, ALU result sources, I/O) and a single consumer stage in the datapath.

Parameters:
- DATA_WIDTH, 16, width of each data word (matches the `DATA_WIDTH macro in parameters.v).
- NUM_CH, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_CH), width of the Sel and Out_Chan ports; derived, not overridden.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Mode  input  2  selection mode: 0 = SELECT, 1 = PRIORITY, 2 = ROUND_ROBIN, 3 = reserved.
- Sel  input  SEL_W  channel index used in SELECT mode.
- In_Valid  input  NUM_CH  per-channel data-valid flags.
- In_Data  input  NUM_CH*DATA_WIDTH  packed channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- In_Ready  output  NUM_CH  per-channel accept strobe (combinational).
- Out_Valid  output  1  output register holds a valid word.
- Out_Ready  input  1  consumer accepts the word this cycle.
- Out_Data  output  DATA_WIDTH  registered selected data.
- Out_Chan  output  SEL_W  channel index that produced Out_Data.

Behaviour:
- Reset: one clock (Clk); reset is asynchronous, active-low (Rst_n).
  - Rst_n low immediately forces Out_Valid=0, Out_Data=0, Out_Chan=0 and round-robin pointer Ptr=0, independent of Clk.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-transfer discards the held word; no In_Ready is asserted while Rst_n is low.
- Load enable: load = !Out_Valid || Out_Ready. This gives full throughput, one word per cycle, with no bubble.
- Grant (combinational, one-hot or zero):
  - SELECT: grant[Sel] = In_Valid[Sel]. If Sel >= NUM_CH, no grant.
  - PRIORITY: lowest-indexed i with In_Valid[i].
  - ROUND_ROBIN: first i with In_Valid[i], searching Ptr, Ptr+1, ..., NUM_CH-1, 0, ..., Ptr-1 (wrap-around).
  - Mode 3: no grant. The output register still drains normally.
- In_Ready[i] = grant[i] && load && Rst_n.
- A transfer on channel i occurs when In_Valid[i] && In_Ready[i].
- Rising edge with load=1:
  - If a grant exists: Out_Data <= In_Data[g], Out_Chan <= g, Out_Valid <= 1.
  - If no grant: Out_Valid <= 0. Out_Data and Out_Chan hold their last value.
- Rising edge with load=0 (Out_Valid=1, Out_Ready=0): all outputs hold; In_Ready is all zero; Ptr holds.
- Latency: one cycle from input transfer to Out_Valid.
- Ptr update:
  - Only on a transfer while Mode=ROUND_ROBIN: Ptr <= (g == NUM_CH-1) ? 0 : g+1.
  - In all other modes Ptr holds.
- Mode or Sel changes take effect on the next grant evaluation. They never disturb a word already held in the output register.
- Simultaneous Out_Ready and a new grant in the same cycle: the old word leaves and the new word loads on the same edge.
- All In_Valid low with Out_Ready high: Out_Valid falls to 0 on the next edge.
- The bench must not depend on Out_Data while Out_Valid=0.

Decomposition:
- parameters.v gains:
  - mode encodings `MUX_MODE_SELECT=0, `MUX_MODE_PRIORITY=1, `MUX_MODE_RR=2;
  - `MUX_NUM_CH default;
  - bench constants `NUM_MUXARB_TEST, `MUXARB_LOWER_BOUND, `MUXARB_UPPER_BOUND.
- One sub-module, rr_grant: purely combinational. Inputs are request vector, pointer and mode; output is the one-hot grant plus its encoded index. Reused later by the bus arbiter.
- The top level holds the output register, Ptr and the handshake.

Test Plan:
- Reset: hold Rst_n=0 with In_Valid=4'b1111 → Out_Valid=0, Out_Data=0, Out_Chan=0, In_Ready=0. Assert Rst_n=0 asynchronously mid-cycle while Out_Valid=1 → Out_Valid=0 before the next edge.
- SELECT: Mode=0, Sel=2, In_Valid=4'b0110, In_Data ch2=0x00AA → one cycle later Out_Data=0x00AA, Out_Chan=2. With Sel=3 and In_Valid=4'b0111 → In_Ready=0, Out_Valid drops to 0.
- PRIORITY: Mode=1, In_Valid=4'b1010, Out_Ready=1 held → Out_Chan sequence 1,1,1 while ch1 stays valid. Drop ch1 → Out_Chan=3.
- ROUND_ROBIN fairness: Mode=2, In_Valid=4'b1111 constant, Out_Ready=1 → Out_Chan sequence 0,1,2,3,0 with Out_Valid high every cycle. With In_Valid=4'b1001 → 0,3,0,3.
- Backpressure: Out_Valid=1, Out_Ready=0 for 3 cycles → Out_Data/Out_Chan stable, In_Ready=0, Ptr unchanged. Then Out_Ready=1 → new word loads on the same edge the old word is accepted.
- Random regression: `NUM_MUXARB_TEST iterations of random Mode (0-2), Sel, In_Valid, Out_Ready and data in [`MUXARB_LOWER_BOUND, `MUXARB_UPPER_BOUND] → a scoreboard model matches Out_Data/Out_Chan. Results are written to Results/mux_arb_n.r and waves to Junk/mux_arb_n.vcd.

Source files
------------

// File: rtl/mux_arb_n_pkg.sv
// -----------------------------------------------------------------------------
// mux_arb_n_pkg
// Shared definitions for the N-channel registered multiplexer/arbiter:
//   - default width / channel count
//   - selection-mode encoding (mode_e)
//   - bench bounds for random data
//   - rr_next(): round-robin pointer successor
// -----------------------------------------------------------------------------
package mux_arb_n_pkg;

    localparam int MUX_DATA_WIDTH     = 16;
    localparam int MUX_NUM_CH         = 4;

    localparam int NUM_MUXARB_TEST    = 200;
    localparam int MUXARB_LOWER_BOUND = 32'h0000_0001;
    localparam int MUXARB_UPPER_BOUND = 32'h0000_FFFE;

    typedef enum logic [1:0] {
        MUX_MODE_SELECT   = 2'd0,
        MUX_MODE_PRIORITY = 2'd1,
        MUX_MODE_RR       = 2'd2,
        MUX_MODE_RSVD     = 2'd3
    } mode_e;

    // Channel that the round-robin search starts from after channel idx won.
    function automatic int rr_next(input int idx, input int num_ch);
        return (idx == num_ch - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// -----------------------------------------------------------------------------
// mux_arb_n_if
// Groups the NUM_CH valid/ready input channels and the single valid/ready
// output channel of mux_arb_n.
//   In_Valid  [NUM_CH]            producer -> mux  per-channel valid
//   In_Data   [NUM_CH*DATA_WIDTH] producer -> mux  channel i at [i*DW +: DW]
//   In_Ready  [NUM_CH]            mux -> producer  per-channel accept
//   Out_Valid                     mux -> consumer  output word valid
//   Out_Ready                     consumer -> mux  consumer accepts
//   Out_Data  [DATA_WIDTH]        mux -> consumer  registered word
//   Out_Chan  [SEL_W]             mux -> consumer  source channel index
// Modports: slave = the mux itself, master = the surrounding producers and
// consumer (or a testbench driving both sides).
// -----------------------------------------------------------------------------
interface mux_arb_n_if
    import mux_arb_n_pkg::*;
#(
    parameter int DATA_WIDTH = MUX_DATA_WIDTH,
    parameter int NUM_CH     = MUX_NUM_CH
);
    localparam int SEL_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            In_Valid;
    logic [NUM_CH*DATA_WIDTH-1:0] In_Data;
    logic [NUM_CH-1:0]            In_Ready;
    logic                         Out_Valid;
    logic                         Out_Ready;
    logic [DATA_WIDTH-1:0]        Out_Data;
    logic [SEL_W-1:0]             Out_Chan;

    modport slave (
        input  In_Valid, In_Data, Out_Ready,
        output In_Ready, Out_Valid, Out_Data, Out_Chan
    );

    modport master (
        output In_Valid, In_Data, Out_Ready,
        input  In_Ready, Out_Valid, Out_Data, Out_Chan
    );

endinterface

// File: rtl/mux_arb_n_rr_grant.sv
// -----------------------------------------------------------------------------
// rr_grant
// Purely combinational grant logic, shared with the bus arbiter.
//   req_i   [NUM_CH]  request vector
//   ptr_i   [SEL_W]   round-robin start channel (always < NUM_CH)
//   sel_i   [SEL_W]   explicit channel for SELECT mode
//   mode_i  mode_e    SELECT / PRIORITY / ROUND_ROBIN / reserved
//   grant_o [NUM_CH]  one-hot grant, or zero
//   idx_o   [SEL_W]   encoded index of the grant (0 when none)
//   any_o             a grant exists
// -----------------------------------------------------------------------------
module rr_grant
    import mux_arb_n_pkg::*;
#(
    parameter int NUM_CH = MUX_NUM_CH,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  mode_e             mode_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic              any_o
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // through the case leaves one unassigned and no latch is inferred.
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;

        unique case (mode_i)
            MUX_MODE_SELECT: begin
                // Sel can exceed NUM_CH-1 when NUM_CH is not a power of two.
                if (int'(sel_i) < NUM_CH) begin
                    if (req_i[sel_i]) begin
                        any_o = 1'b1;
                        idx_o = sel_i;
                    end
                end
            end
            MUX_MODE_PRIORITY: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!any_o && req_i[i]) begin
                        any_o = 1'b1;
                        idx_o = SEL_W'(i);
                    end
                end
            end
            MUX_MODE_RR: begin
                // Search ptr, ptr+1, ..., wrapping back to ptr-1.
                for (int k = 0; k < NUM_CH; k++) begin
                    int j;
                    j = int'(ptr_i) + k;
                    if (j >= NUM_CH) j = j - NUM_CH;
                    if (!any_o && req_i[j]) begin
                        any_o = 1'b1;
                        idx_o = SEL_W'(j);
                    end
                end
            end
            default: ; // reserved mode: never grants
        endcase

        if (any_o) grant_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/mux_arb_n.sv
// -----------------------------------------------------------------------------
// mux_arb_n
// N-channel registered multiplexer: picks one valid input channel (explicit
// select, fixed priority or round-robin) and registers its word and channel
// index on a single valid/ready output. One word per cycle, one cycle latency.
//   Clk    system clock, rising edge
//   Rst_n  asynchronous active-low reset
//   Mode   [2]      0 SELECT, 1 PRIORITY, 2 ROUND_ROBIN, 3 reserved (no grant)
//   Sel    [SEL_W]  channel used in SELECT mode
//   bus    mux_arb_n_if.slave: input channels and output channel
// -----------------------------------------------------------------------------
module mux_arb_n
    import mux_arb_n_pkg::*;
#(
    parameter  int DATA_WIDTH = MUX_DATA_WIDTH,
    parameter  int NUM_CH     = MUX_NUM_CH,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [1:0]       Mode,
    input  logic [SEL_W-1:0] Sel,
    mux_arb_n_if.slave       bus
);

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]      out_chan_q,  out_chan_d;
    logic [SEL_W-1:0]      ptr_q,       ptr_d;

    mode_e                 mode;
    logic                  load;
    logic [NUM_CH-1:0]     grant;
    logic [SEL_W-1:0]      grant_idx;
    logic                  grant_any;

    assign mode = mode_e'(Mode);

    // Output register may take a new word when empty or being drained.
    assign load = !out_valid_q || bus.Out_Ready;

    rr_grant #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_grant (
        .req_i   (bus.In_Valid),
        .ptr_i   (ptr_q),
        .sel_i   (Sel),
        .mode_i  (mode),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // Rst_n gates the strobe so no producer sees an accept during reset.
    assign bus.In_Ready = grant & {NUM_CH{load && Rst_n}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;

        if (load) begin
            if (grant_any) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.In_Data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                out_chan_d  = grant_idx;
                if (mode == MUX_MODE_RR) begin
                    ptr_d = SEL_W'(rr_next(int'(grant_idx), NUM_CH));
                end
            end else begin
                // Data and channel keep their last value; only valid drops.
                out_valid_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, and every one
    // of them (data included) is cleared by the asynchronous reset so the
    // output is defined the moment Rst_n falls, without waiting for Clk.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.Out_Valid = out_valid_q;
    assign bus.Out_Data  = out_data_q;
    assign bus.Out_Chan  = out_chan_q;

endmodule
